// File: rtl/dup_pkg.sv
// rtl/dup_pkg.sv - shared types and constants for the double-up round sequencer
//   Contents: dup_state_e round states, RES_* result codes, GUESS_* guess codes,
//   CARD_MIN/CARD_MAX rank bounds, card_is_valid() rank check.
package dup_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DEAL       = 3'd1,
    WAIT_GUESS = 3'd2,
    DRAW       = 3'd3,
    JUDGE      = 3'd4,
    FINISH     = 3'd5
  } dup_state_e;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_DRAW = 2'b10;
  localparam logic [1:0] RES_LOSE = 2'b11;

  localparam logic [1:0] GUESS_HIGH = 2'b01;
  localparam logic [1:0] GUESS_LOW  = 2'b10;

  localparam logic [3:0] CARD_MIN = 4'd1;
  localparam logic [3:0] CARD_MAX = 4'd13;

  function automatic logic card_is_valid(input logic [3:0] val);
    return (val >= CARD_MIN) && (val <= CARD_MAX);
  endfunction

endpackage

// File: rtl/dup_round_ctrl_if.sv
// rtl/dup_round_ctrl_if.sv - player, card-source and credit/display signals of one double-up round
//   Parameter: CREDIT_W credit width.
//   master: the round sequencer (drives card_req and all result/credit outputs).
//   slave : the surrounding logic (drives start/credit_in, guess, collect, card_ack/card_val).
interface dup_round_ctrl_if #(
  parameter int CREDIT_W = 16
);
  logic                start;
  logic [CREDIT_W-1:0] credit_in;
  logic [1:0]          guess;
  logic                guess_valid;
  logic                collect;
  logic                card_req;
  logic                card_ack;
  logic [3:0]          card_val;
  logic [3:0]          cur_card;
  logic [3:0]          next_card;
  logic [1:0]          result;
  logic                result_valid;
  logic [3:0]          win_count;
  logic [CREDIT_W-1:0] credit_out;
  logic                busy;
  logic                done;

  modport master (
    input  start, credit_in, guess, guess_valid, collect, card_ack, card_val,
    output card_req, cur_card, next_card, result, result_valid, win_count,
           credit_out, busy, done
  );

  modport slave (
    output start, credit_in, guess, guess_valid, collect, card_ack, card_val,
    input  card_req, cur_card, next_card, result, result_valid, win_count,
           credit_out, busy, done
  );
endinterface

// File: rtl/dup_compare.sv
// rtl/dup_compare.sv - combinational judge of a high/low guess against two card ranks
//   guess     in  2  GUESS_HIGH / GUESS_LOW
//   cur_card  in  4  face-up base card
//   next_card in  4  challenge card
//   result    out 2  RES_WIN / RES_DRAW / RES_LOSE
module dup_compare
  import dup_pkg::*;
(
  input  logic [1:0] guess,
  input  logic [3:0] cur_card,
  input  logic [3:0] next_card,
  output logic [1:0] result
);

  always_comb begin
    result = RES_LOSE;
    if (next_card == cur_card) begin
      result = RES_DRAW;
    end else if ((guess == GUESS_HIGH) && (next_card > cur_card)) begin
      result = RES_WIN;
    end else if ((guess == GUESS_LOW) && (next_card < cur_card)) begin
      result = RES_WIN;
    end
  end

endmodule

// File: rtl/dup_round_ctrl.sv
// rtl/dup_round_ctrl.sv - double-up round sequencer: deal, guess, draw, judge, payout
//   Optional feature macro: DUP_TIMEOUT_EN (guess-wait timeout acting as collect).
//   Parameters: CREDIT_W credit width, MAX_WINS win cap (1..15), TIMEOUT_CYC guess-wait limit.
//   clock   in  system clock
//   reset_c in  synchronous active-high reset
//   bus     master side of dup_round_ctrl_if (player strobes, card handshake, credit/result outputs)
module dup_round_ctrl
  import dup_pkg::*;
#(
  parameter int CREDIT_W    = 16,
  parameter int MAX_WINS    = 10,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clock,
  input  logic               reset_c,
  dup_round_ctrl_if.master   bus
);

  localparam logic [3:0] MAX_WINS_C = 4'(MAX_WINS);

  dup_state_e          state_q, state_d;
  logic                card_req_q, card_req_d;
  logic [3:0]          cur_card_q, cur_card_d;
  logic [3:0]          next_card_q, next_card_d;
  logic [1:0]          guess_q, guess_d;
  logic [1:0]          result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic [3:0]          win_count_q, win_count_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [1:0]          cmp_result;
  logic [CREDIT_W-1:0] credit_dbl;
  logic [3:0]          win_count_inc;
  logic                timeout;

  dup_compare u_compare (
    .guess     (guess_q),
    .cur_card  (cur_card_q),
    .next_card (next_card_q),
    .result    (cmp_result)
  );

  // Doubling saturates: once the MSB is set the shifted value would wrap.
  assign credit_dbl    = credit_q[CREDIT_W-1] ? '1 : {credit_q[CREDIT_W-2:0], 1'b0};
  assign win_count_inc = win_count_q + 4'd1;

`ifdef DUP_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [TMR_W-1:0] timer_q, timer_d;

  // Counts cycles spent in WAIT_GUESS; any other state holds it at zero so
  // every entry into WAIT_GUESS starts a fresh window.
  always_comb begin
    timer_d = '0;
    if (state_q == WAIT_GUESS) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_c) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timeout = (state_q == WAIT_GUESS) && (timer_q == TMR_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    card_req_d     = card_req_q;
    cur_card_d     = cur_card_q;
    next_card_d    = next_card_q;
    guess_d        = guess_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    win_count_d    = win_count_q;
    credit_d       = credit_q;
    busy_d         = busy_q;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.credit_in != '0)) begin
          state_d     = DEAL;
          card_req_d  = 1'b1;
          busy_d      = 1'b1;
          credit_d    = bus.credit_in;
          win_count_d = '0;
          result_d    = RES_NONE;
        end
      end

      // Invalid ranks are dropped and card_req stays up for a redraw.
      DEAL: begin
        if (bus.card_ack && card_is_valid(bus.card_val)) begin
          cur_card_d = bus.card_val;
          card_req_d = 1'b0;
          state_d    = WAIT_GUESS;
        end
      end

      // Collect (or timeout) beats a guess arriving in the same cycle.
      WAIT_GUESS: begin
        if (bus.collect || timeout) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (bus.guess_valid &&
                     ((bus.guess == GUESS_HIGH) || (bus.guess == GUESS_LOW))) begin
          guess_d    = bus.guess;
          card_req_d = 1'b1;
          state_d    = DRAW;
        end
      end

      DRAW: begin
        if (bus.card_ack && card_is_valid(bus.card_val)) begin
          next_card_d = bus.card_val;
          card_req_d  = 1'b0;
          state_d     = JUDGE;
        end
      end

      JUDGE: begin
        result_d       = cmp_result;
        result_valid_d = 1'b1;
        case (cmp_result)
          RES_WIN: begin
            credit_d    = credit_dbl;
            win_count_d = win_count_inc;
            cur_card_d  = next_card_q;
            if (win_count_inc == MAX_WINS_C) begin
              state_d = FINISH;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = WAIT_GUESS;
            end
          end
          RES_DRAW: begin
            cur_card_d = next_card_q;
            state_d    = WAIT_GUESS;
          end
          default: begin
            credit_d = '0;
            state_d  = FINISH;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        endcase
      end

      // done/busy were already set on the way in; just return to IDLE.
      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_c) begin
      state_q        <= IDLE;
      card_req_q     <= 1'b0;
      cur_card_q     <= '0;
      next_card_q    <= '0;
      guess_q        <= '0;
      result_q       <= RES_NONE;
      result_valid_q <= 1'b0;
      win_count_q    <= '0;
      credit_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      card_req_q     <= card_req_d;
      cur_card_q     <= cur_card_d;
      next_card_q    <= next_card_d;
      guess_q        <= guess_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      win_count_q    <= win_count_d;
      credit_q       <= credit_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.card_req     = card_req_q;
  assign bus.cur_card     = cur_card_q;
  assign bus.next_card    = next_card_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.win_count    = win_count_q;
  assign bus.credit_out   = credit_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_dup_round_ctrl.sv
// tb/tb_dup_round_ctrl.sv - directed self-checking bench for dup_round_ctrl
module tb_dup_round_ctrl;
  import dup_pkg::*;

  localparam int CREDIT_W    = 16;
  localparam int MAX_WINS    = 3;
  localparam int TIMEOUT_CYC = 20;

  logic clock;
  logic reset_c;
  int   n_cmp;
  int   n_err;

  dup_round_ctrl_if #(.CREDIT_W(CREDIT_W)) bus ();

  dup_round_ctrl #(
    .CREDIT_W    (CREDIT_W),
    .MAX_WINS    (MAX_WINS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock   (clock),
    .reset_c (reset_c),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_game(input logic [15:0] credit);
    bus.start     = 1'b1;
    bus.credit_in = credit;
    tick();
    bus.start     = 1'b0;
    bus.credit_in = '0;
  endtask

  task automatic give_card(input logic [3:0] val);
    int n;
    n = 0;
    while (!bus.card_req && n < 20) begin
      tick();
      n++;
    end
    if (!bus.card_req) expect_eq("card_req_wait", 32'(bus.card_req), 32'd1);
    bus.card_ack = 1'b1;
    bus.card_val = val;
    tick();
    bus.card_ack = 1'b0;
    bus.card_val = '0;
  endtask

  task automatic do_guess(input logic [1:0] g);
    bus.guess_valid = 1'b1;
    bus.guess       = g;
    tick();
    bus.guess_valid = 1'b0;
    bus.guess       = '0;
  endtask

  // Challenge card then the JUDGE cycle; returns positioned on the result_valid cycle.
  task automatic draw_and_judge(input string tag, input logic [3:0] val);
    give_card(val);
    expect_eq({tag, "_rv_early"}, 32'(bus.result_valid), 32'd0);
    tick();
    expect_eq({tag, "_rv"}, 32'(bus.result_valid), 32'd1);
  endtask

  initial begin
    int n;
    n_cmp           = 0;
    n_err           = 0;
    reset_c         = 1'b1;
    bus.start       = 1'b0;
    bus.credit_in   = '0;
    bus.guess       = '0;
    bus.guess_valid = 1'b0;
    bus.collect     = 1'b0;
    bus.card_ack    = 1'b0;
    bus.card_val    = '0;
    tick();
    tick();
    reset_c = 1'b0;

    // Reset state
    expect_eq("rst_card_req", 32'(bus.card_req), 32'd0);
    expect_eq("rst_cur_card", 32'(bus.cur_card), 32'd0);
    expect_eq("rst_result", 32'(bus.result), 32'd0);
    expect_eq("rst_credit", 32'(bus.credit_out), 32'd0);
    expect_eq("rst_busy_done", 32'({bus.busy, bus.done, bus.result_valid}), 32'd0);

    // Zero-credit start ignored
    start_game(16'd0);
    expect_eq("zero_start_busy", 32'(bus.busy), 32'd0);
    expect_eq("zero_start_req", 32'(bus.card_req), 32'd0);

    // Basic win: 100, base 5, high, 9
    start_game(16'd100);
    expect_eq("win_busy", 32'(bus.busy), 32'd1);
    expect_eq("win_req", 32'(bus.card_req), 32'd1);
    give_card(4'd5);
    expect_eq("win_base", 32'(bus.cur_card), 32'd5);
    expect_eq("win_req_drop", 32'(bus.card_req), 32'd0);
    do_guess(GUESS_HIGH);
    expect_eq("win_draw_req", 32'(bus.card_req), 32'd1);
    draw_and_judge("win", 4'd9);
    expect_eq("win_result", 32'(bus.result), 32'(RES_WIN));
    expect_eq("win_credit", 32'(bus.credit_out), 32'd200);
    expect_eq("win_count", 32'(bus.win_count), 32'd1);
    expect_eq("win_cur", 32'(bus.cur_card), 32'd9);
    expect_eq("win_still_busy", 32'({bus.busy, bus.done, bus.card_req}), 32'b100);
    tick();
    expect_eq("win_rv_pulse", 32'(bus.result_valid), 32'd0);
    bus.collect = 1'b1;
    tick();
    bus.collect = 1'b0;
    expect_eq("collect_done", 32'({bus.done, bus.busy}), 32'b10);
    expect_eq("collect_credit", 32'(bus.credit_out), 32'd200);
    tick();
    expect_eq("collect_done_pulse", 32'(bus.done), 32'd0);

    // Draw then lose
    start_game(16'd50);
    give_card(4'd7);
    do_guess(GUESS_LOW);
    draw_and_judge("draw", 4'd7);
    expect_eq("draw_result", 32'(bus.result), 32'(RES_DRAW));
    expect_eq("draw_credit", 32'(bus.credit_out), 32'd50);
    expect_eq("draw_count", 32'(bus.win_count), 32'd0);
    tick();
    do_guess(GUESS_LOW);
    draw_and_judge("lose", 4'd12);
    expect_eq("lose_result", 32'(bus.result), 32'(RES_LOSE));
    expect_eq("lose_credit", 32'(bus.credit_out), 32'd0);
    expect_eq("lose_done_busy", 32'({bus.done, bus.busy}), 32'b10);
    tick();

    // Win cap at MAX_WINS = 3
    start_game(16'd1);
    give_card(4'd2);
    do_guess(GUESS_HIGH);
    draw_and_judge("cap1", 4'd5);
    tick();
    do_guess(GUESS_HIGH);
    draw_and_judge("cap2", 4'd9);
    tick();
    do_guess(GUESS_LOW);
    draw_and_judge("cap3", 4'd3);
    expect_eq("cap_credit", 32'(bus.credit_out), 32'd8);
    expect_eq("cap_count", 32'(bus.win_count), 32'd3);
    expect_eq("cap_done", 32'({bus.done, bus.busy}), 32'b10);
    tick();

    // Invalid cards, bad guess code, collect beating guess
    start_game(16'd10);
    give_card(4'd0);
    expect_eq("inv0_req", 32'(bus.card_req), 32'd1);
    expect_eq("inv0_cur", 32'(bus.cur_card), 32'd3);
    give_card(4'd14);
    expect_eq("inv14_req", 32'(bus.card_req), 32'd1);
    give_card(4'd6);
    expect_eq("inv_cur", 32'(bus.cur_card), 32'd6);
    expect_eq("inv_req_drop", 32'(bus.card_req), 32'd0);
    do_guess(2'b11);
    expect_eq("bad_guess_req", 32'(bus.card_req), 32'd0);
    bus.collect     = 1'b1;
    bus.guess_valid = 1'b1;
    bus.guess       = GUESS_HIGH;
    tick();
    bus.collect     = 1'b0;
    bus.guess_valid = 1'b0;
    expect_eq("both_req", 32'(bus.card_req), 32'd0);
    expect_eq("both_done", 32'(bus.done), 32'd1);
    expect_eq("both_credit", 32'(bus.credit_out), 32'd10);
    tick();

    // Saturation, ignored collect/start, reset during DRAW
    start_game(16'hC000);
    bus.collect = 1'b1;
    tick();
    bus.collect = 1'b0;
    expect_eq("deal_collect_ignored", 32'({bus.busy, bus.done}), 32'b10);
    give_card(4'd2);
    do_guess(GUESS_HIGH);
    draw_and_judge("sat", 4'd10);
    expect_eq("sat_credit", 32'(bus.credit_out), 32'hFFFF);
    start_game(16'd5);
    expect_eq("busy_start_ignored", 32'(bus.credit_out), 32'hFFFF);
    do_guess(GUESS_LOW);
    expect_eq("pre_rst_req", 32'(bus.card_req), 32'd1);
    reset_c = 1'b1;
    tick();
    reset_c = 1'b0;
    expect_eq("midrst_req", 32'(bus.card_req), 32'd0);
    expect_eq("midrst_cards", 32'({bus.cur_card, bus.next_card}), 32'd0);
    expect_eq("midrst_credit", 32'(bus.credit_out), 32'd0);
    expect_eq("midrst_flags", 32'({bus.busy, bus.done, bus.result_valid, bus.result, bus.win_count}), 32'd0);

`ifdef DUP_TIMEOUT_EN
    start_game(16'd3);
    give_card(4'd4);
    n = 0;
    while (!bus.done && n < TIMEOUT_CYC + 5) begin
      tick();
      n++;
    end
    expect_eq("timeout_done", 32'(bus.done), 32'd1);
    expect_eq("timeout_credit", 32'(bus.credit_out), 32'd3);
    tick();
`else
    n = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
